fmadd_lzd_norm_stage: RTL and testbench
=======================================

// Module: fmadd_lzd_norm_stage
// PURPOSE
//  Normalization stage directly downstream of the FMADD leading-zero-detector tree.
//  Consumes the final LZD result and the unnormalized FMADD mantissa and exponent.
//  Left-shifts the mantissa so its MSB is the leading one, and subtracts the shift from the exponent.
//  Two-stage valid/ready pipeline. Feeds the FMADD rounding/pack stage.
// PARAMETERS
//  MAN_W = 24  width of the unnormalized mantissa (the LZD covers all MAN_W bits)
//  POS_W = 5   width of the LZD leading-zero count; 2**POS_W >= MAN_W
//  EXP_W = 8   biased exponent width (bfloat16)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_l      in   1      asynchronous active-low reset
//  in_valid   in   1      upstream beat valid
//  in_ready   out  1      stage can accept a beat
//  in_sign    in   1      result sign, passed through unchanged
//  in_exp     in   EXP_W  biased exponent before normalization
//  in_man     in   MAN_W  unnormalized mantissa magnitude
//  lzd_val    in   1      1 = a one exists in in_man; 0 = in_man is all zero
//  lzd_pos    in   POS_W  leading-zero count of in_man (valid when lzd_val=1)
//  out_valid  out  1      normalized beat valid
//  out_ready  in   1      downstream accepts the beat
//  out_sign   out  1      sign
//  out_exp    out  EXP_W  adjusted exponent
//  out_man    out  MAN_W  normalized mantissa
//  out_zero   out  1      result is exact zero
//  out_uflow  out  1      exponent underflow occurred
// BEHAVIOUR
//  - Reset (rst_l=0, async): both stage valids clear. All out_* data outputs and flags reset to 0.
//    in_ready=1 while reset is deasserted and the pipe is empty.
//    A reset during operation discards all in-flight beats; there is no partial output.
//  - Beat transfer: a beat moves on a rising clk edge when valid && ready on that interface.
//    Data must be held stable while valid=1 && ready=0. out_valid never drops without out_ready.
//  - Pipeline control:
//    - S1 advances when !s2_valid || out_ready.
//    - in_ready = !s1_valid || (S1 advances); combinational, no bubble at full throughput.
//    - Simultaneous accept and drain in the same cycle is legal and required.
//  - S1 (register + decide):
//    - Latch sign, exp, man, lzd_val and lzd_pos.
//    - Compute shamt = lzd_pos, zero = !lzd_val, uf = lzd_val && (lzd_pos >= in_exp).
//  - S2 (shift + adjust):
//    - Normal case: out_man = man << shamt; out_exp = exp - shamt (EXP_W bits, no wrap possible).
//    - zero=1: out_man=0, out_exp=0, out_zero=1, out_uflow=0. The sign is still passed through.
//    - uf=1: see CONFIGURATION.
//  - Latency: 2 cycles from in accept to out_valid when there is no backpressure. Throughput is 1 beat/cycle.
//  - Order is preserved. No beat is dropped or duplicated under any out_ready pattern.
//  - lzd_pos >= MAN_W with lzd_val=1 is illegal input. The bench asserts it never occurs.
// CONFIGURATION
//  FMADD_NORM_SUBNORM_EN
//  - Undefined (default), uf=1: flush to zero. out_man=0, out_exp=0, out_uflow=1, out_zero=1.
//  - Defined, uf=1: produce a subnormal. The shift is clamped to shamt = exp-1 (0 when exp=0).
//    out_man = man << shamt, out_exp = 0, out_uflow = 1, out_zero = 0.
// TESTING
//  1. Normal: man=24'h000180, lzd_pos=15, exp=100 -> after 2 clk: out_man=24'hC00000, out_exp=85, zero=0, uflow=0.
//  2. Zero: lzd_val=0, man=0, exp=77, sign=1 -> out_man=0, out_exp=0, out_zero=1, out_sign=1.
//  3. Underflow: man=24'h000001, lzd_pos=23, exp=10.
//     - Macro off -> out_man=0, out_exp=0, out_uflow=1, out_zero=1.
//     - Macro on  -> out_man=24'h000200, out_exp=0, out_uflow=1, out_zero=0.
//  4. Backpressure:
//     - Stimulus: stream beats A,B,C back-to-back while out_ready=0 for 4 cycles.
//     - Required response: in_ready=0 once A and B are held. Then raise out_ready.
//       A, B, C emerge in order, one per cycle, with unchanged data.
//  5. Full throughput: 8 beats back-to-back with out_ready=1 -> in_ready stays 1 and 8 consecutive out_valid cycles occur.
//  6. Async reset: assert rst_l=0 mid-stream between clk edges -> out_valid=0 immediately.
//     After release, the first new beat emerges after 2 cycles with no stale data.

Source files
------------

// File: rtl/fmadd_lzd_norm_stage.sv
// FMADD normalization stage: S1 registers the LZD result and classifies the beat,
// S2 shifts the mantissa and adjusts the exponent. Define FMADD_NORM_SUBNORM_EN for subnormal output on underflow.
module fmadd_lzd_norm_stage #(
  parameter int MAN_W = 24,
  parameter int POS_W = 5,
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W-1:0] in_man,
  input  logic             lzd_val,
  input  logic [POS_W-1:0] lzd_pos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_man,
  output logic             out_zero,
  output logic             out_uflow
);

  localparam int CMP_W = (POS_W > EXP_W) ? POS_W : EXP_W;

  logic             s1_valid_q;
  logic             s1_sign_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [MAN_W-1:0] s1_man_q;
  logic [POS_W-1:0] s1_shamt_q;
  logic             s1_zero_q;
  logic             s1_uf_q;
  logic             s1_uf_d;

  logic             s2_valid_q;
  logic             s2_sign_q;
  logic [EXP_W-1:0] s2_exp_q,  s2_exp_d;
  logic [MAN_W-1:0] s2_man_q,  s2_man_d;
  logic             s2_zero_q, s2_zero_d;
  logic             s2_uflow_q, s2_uflow_d;

  logic s1_adv;
  logic in_fire;
  logic s2_load;

  // S1 may hand its beat to S2 whenever S2 is empty or being drained this cycle.
  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_adv && s1_valid_q;

  assign s1_uf_d = lzd_val && (CMP_W'(lzd_pos) >= CMP_W'(in_exp));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_man_q   <= '0;
      s1_shamt_q <= '0;
      s1_zero_q  <= 1'b0;
      s1_uf_q    <= 1'b0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (in_fire) begin
        s1_sign_q  <= in_sign;
        s1_exp_q   <= in_exp;
        s1_man_q   <= in_man;
        s1_shamt_q <= lzd_pos;
        s1_zero_q  <= !lzd_val;
        s1_uf_q    <= s1_uf_d;
      end
    end
  end

`ifdef FMADD_NORM_SUBNORM_EN
  logic [POS_W-1:0] sub_shamt;
  // Underflow implies exp <= lzd_pos < MAN_W, so exp-1 always fits the shift width.
  assign sub_shamt = (s1_exp_q == '0) ? '0 : POS_W'(s1_exp_q - 1'b1);
`endif

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    s2_man_d   = s1_man_q << s1_shamt_q;
    s2_exp_d   = s1_exp_q - EXP_W'(s1_shamt_q);
    s2_zero_d  = 1'b0;
    s2_uflow_d = 1'b0;
    if (s1_zero_q) begin
      s2_man_d  = '0;
      s2_exp_d  = '0;
      s2_zero_d = 1'b1;
    end else if (s1_uf_q) begin
`ifdef FMADD_NORM_SUBNORM_EN
      s2_man_d   = s1_man_q << sub_shamt;
      s2_exp_d   = '0;
      s2_uflow_d = 1'b1;
`else
      s2_man_d   = '0;
      s2_exp_d   = '0;
      s2_zero_d  = 1'b1;
      s2_uflow_d = 1'b1;
`endif
    end
  end

  // NOTE: output data registers are reset too, so the pack stage never sees X after reset.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_man_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_uflow_q <= 1'b0;
    end else begin
      if (s1_adv) s2_valid_q <= s1_valid_q;
      if (s2_load) begin
        s2_sign_q  <= s1_sign_q;
        s2_exp_q   <= s2_exp_d;
        s2_man_q   <= s2_man_d;
        s2_zero_q  <= s2_zero_d;
        s2_uflow_q <= s2_uflow_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sign  = s2_sign_q;
  assign out_exp   = s2_exp_q;
  assign out_man   = s2_man_q;
  assign out_zero  = s2_zero_q;
  assign out_uflow = s2_uflow_q;

endmodule

// File: tb/tb_fmadd_lzd_norm_stage.sv
// Self-checking bench for fmadd_lzd_norm_stage: directed vectors, backpressure, throughput,
// async reset and randomized traffic against an arithmetic reference model.
`timescale 1ns/1ps
module tb_fmadd_lzd_norm_stage;

  localparam int MAN_W = 24;
  localparam int POS_W = 5;
  localparam int EXP_W = 8;

  logic             clk = 1'b0;
  logic             rst_l;
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_man;
  logic             lzd_val;
  logic [POS_W-1:0] lzd_pos;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [EXP_W-1:0] out_exp;
  logic [MAN_W-1:0] out_man;
  logic             out_zero;
  logic             out_uflow;

  fmadd_lzd_norm_stage #(.MAN_W(MAN_W), .POS_W(POS_W), .EXP_W(EXP_W)) dut (
    .clk(clk), .rst_l(rst_l),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign), .in_exp(in_exp),
    .in_man(in_man), .lzd_val(lzd_val), .lzd_pos(lzd_pos),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_exp(out_exp),
    .out_man(out_man), .out_zero(out_zero), .out_uflow(out_uflow)
  );

  always #5 clk = ~clk;

  typedef logic [34:0] res_t;  // {sign, exp, man, zero, uflow}

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] man;
    logic        lv;
    logic [4:0]  pos;
    res_t        expect_res;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  res_t exp_q[$];
  int   out_cycles[$];
  logic stalled = 1'b0;
  logic last_in_fire = 1'b0;
  res_t held;
  vec_t tbl[8];

  wire res_t got = {out_sign, out_exp, out_man, out_zero, out_uflow};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int lead_zeros(input logic [23:0] m);
    int k = 0;
    while (k < MAN_W && (longint'(1) << k) <= longint'(m)) k++;
    return MAN_W - k;
  endfunction

  // Reference: normalize by multiplying with a power of two, flush or denormalize on underflow.
  function automatic res_t ref_model(input logic s, input logic [7:0] e, input logic [23:0] m);
    int     lz;
    int     sh;
    longint mm;
    if (m == 0) return {s, 8'd0, 24'd0, 1'b1, 1'b0};
    lz = lead_zeros(m);
    if (lz < int'(e)) begin
      mm = longint'(m) * (longint'(1) << lz);
      return {s, 8'(int'(e) - lz), 24'(mm), 1'b0, 1'b0};
    end
`ifdef FMADD_NORM_SUBNORM_EN
    sh = (e == 0) ? 0 : int'(e) - 1;
    mm = longint'(m) * (longint'(1) << sh);
    return {s, 8'd0, 24'(mm), 1'b0, 1'b1};
`else
    sh = 0;
    return {s, 8'd0, 24'd0, 1'b1, 1'b1};
`endif
  endfunction

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic cycle();
    @(negedge clk);
    assert (!(in_valid && lzd_val && lzd_pos >= 5'(MAN_W))) else $error("illegal lzd_pos driven");
    if (stalled) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", got, held);
    end
    stalled = out_valid && !out_ready;
    held    = got;
    if (out_valid && out_ready) begin
      out_cycles.push_back(cyc);
      if (exp_q.size() == 0) check("spurious_out", out_valid, 1'b0);
      else check("sb_data", got, exp_q.pop_front());
    end
    last_in_fire = in_valid && in_ready;
    if (last_in_fire) exp_q.push_back(ref_model(in_sign, in_exp, in_man));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_in(input logic s, input logic [7:0] e, input logic [23:0] m);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_man   = m;
    lzd_val  = (m != 0);
    lzd_pos  = (m != 0) ? 5'(lead_zeros(m)) : 5'($urandom_range(0, 31));
  endtask

  task automatic rand_beat();
    logic [23:0] m;
    logic [7:0]  e;
    m = 24'($urandom) >> $urandom_range(0, 24);
    e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 30));
    set_in(1'($urandom), e, m);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    res_t a_res;

    tbl[0] = '{1'b0, 8'd100, 24'h000180, 1'b1, 5'd15, {1'b0, 8'd85, 24'hC00000, 2'b00}};
    tbl[1] = '{1'b1, 8'd77,  24'h000000, 1'b0, 5'd0,  {1'b1, 8'd0,  24'h000000, 2'b10}};
    tbl[2] = '{1'b0, 8'd24,  24'h000001, 1'b1, 5'd23, {1'b0, 8'd1,  24'h800000, 2'b00}};
    tbl[3] = '{1'b0, 8'd255, 24'h800000, 1'b1, 5'd0,  {1'b0, 8'd255, 24'h800000, 2'b00}};
    tbl[4] = '{1'b0, 8'd0,   24'h000000, 1'b0, 5'd9,  {1'b0, 8'd0,  24'h000000, 2'b10}};
`ifdef FMADD_NORM_SUBNORM_EN
    tbl[5] = '{1'b0, 8'd10,  24'h000001, 1'b1, 5'd23, {1'b0, 8'd0,  24'h000200, 2'b01}};
    tbl[6] = '{1'b1, 8'd16,  24'h0000FF, 1'b1, 5'd16, {1'b1, 8'd0,  24'h7F8000, 2'b01}};
    tbl[7] = '{1'b1, 8'd0,   24'hABCDEF, 1'b1, 5'd0,  {1'b1, 8'd0,  24'hABCDEF, 2'b01}};
`else
    tbl[5] = '{1'b0, 8'd10,  24'h000001, 1'b1, 5'd23, {1'b0, 8'd0,  24'h000000, 2'b11}};
    tbl[6] = '{1'b1, 8'd16,  24'h0000FF, 1'b1, 5'd16, {1'b1, 8'd0,  24'h000000, 2'b11}};
    tbl[7] = '{1'b1, 8'd0,   24'hABCDEF, 1'b1, 5'd0,  {1'b1, 8'd0,  24'h000000, 2'b11}};
`endif

    rst_l = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_man = '0;
    lzd_val = 1'b0; lzd_pos = '0; out_ready = 1'b0;
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_data", got, 35'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_l = 1'b1;

    // Directed vectors, one at a time, checking the two-cycle latency.
    foreach (tbl[i]) begin
      out_ready = 1'b1;
      in_valid = 1'b1; in_sign = tbl[i].sign; in_exp = tbl[i].exp; in_man = tbl[i].man;
      lzd_val = tbl[i].lv; lzd_pos = tbl[i].pos;
      cycle();
      in_valid = 1'b0;
      cycle();
      check($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      check($sformatf("vec%0d_data", i), got, tbl[i].expect_res);
      cycle();
    end

    // Backpressure: A and B fill the pipe, C is held off until out_ready rises.
    out_ready = 1'b0;
    set_in(1'b0, 8'd60, 24'h00A5A5); cycle();
    set_in(1'b1, 8'd90, 24'h3C0000); cycle();
    set_in(1'b0, 8'd5,  24'h000F00);
    check("bp_in_ready_low", in_ready, 1'b0);
    cycle(); cycle();
    check("bp_out_valid", out_valid, 1'b1);
    n0 = out_cycles.size();
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle(); cycle(); cycle();
    check("bp_count", out_cycles.size() - n0, 3);
    check("bp_consec", out_cycles[n0 + 2] - out_cycles[n0], 2);

    // Full throughput: eight beats back to back.
    n0 = out_cycles.size();
    for (int i = 0; i < 8; i++) begin
      rand_beat();
      check("tp_in_ready", in_ready, 1'b1);
      cycle();
    end
    in_valid = 1'b0;
    cycle(); cycle(); cycle();
    check("tp_count", out_cycles.size() - n0, 8);
    check("tp_consec", out_cycles[out_cycles.size() - 1] - out_cycles[n0], 7);

    // Async reset in the middle of a stream.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 8'd200, 24'h00FFFF ^ 24'(i)); cycle();
    end
    #2 rst_l = 1'b0;
    in_valid = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_data", got, 35'd0);
    check("arst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    stalled = 1'b0;
    cycle(); cycle();
    rst_l = 1'b1;
    cycle();
    check("post_rst_idle", out_valid, 1'b0);
    set_in(1'b1, 8'd50, 24'h001234);
    a_res = ref_model(1'b1, 8'd50, 24'h001234);
    cycle();
    in_valid = 1'b0;
    cycle();
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_data", got, a_res);
    cycle();
    check("post_rst_no_stale", out_valid, 1'b0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!(in_valid && !last_in_fire)) begin
        if ($urandom_range(0, 4) != 0) rand_beat();
        else in_valid = 1'b0;
      end
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      cycle();
    end
    check("drain_empty", exp_q.size(), 0);
    cycle();
    check("drain_idle", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
